// File: rtl/hilo_md_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_md_sched_pkg
//  Description : Shared types and constants for the HI/LO multiply/divide
//                scheduler (operation encoding, FSM states, divider constants,
//                sign helpers).
//  Revision    : 1.0 - initial release
// ============================================================================
package hilo_md_sched_pkg;

  // One-hot HI/LO operation; field order matches the req_op bit order
  // {mult, multu, div, divu, mfhi, mflo, mthi, mtlo} with mult as bit 7.
  typedef struct packed {
    logic mult;
    logic multu;
    logic div;
    logic divu;
    logic mfhi;
    logic mflo;
    logic mthi;
    logic mtlo;
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  localparam int          MD_DIV_ITER     = 32;
  localparam int          MD_CNT_W        = 5;
  localparam logic [31:0] DIV_BY_ZERO_QUO = 32'hFFFF_FFFF;

  // Magnitude of a 32-bit operand; only negative signed values are flipped.
  function automatic logic [31:0] md_abs(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  // Conditional two's-complement negation used by the divide sign fix-up.
  function automatic logic [31:0] md_neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : md_div_step
//  Description : One combinational restoring-division step. The quotient
//                register initially holds the dividend; each step shifts one
//                dividend bit into the remainder, trial-subtracts the divisor
//                and shifts the resulting quotient bit in from the right.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] dvs_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] w_shift;
  logic [32:0] w_trial;

  // Remainder stays below the divisor, so 33 bits hold the shifted value and
  // bit 32 of the trial difference is a clean borrow flag. A zero divisor
  // never borrows, giving an all-ones quotient and remainder == dividend.
  always_comb begin
    w_shift = {rem_i, quo_i[31]};
    w_trial = w_shift - {1'b0, dvs_i};
    if (!w_trial[32]) begin
      rem_o = w_trial[31:0];
      quo_o = {quo_i[30:0], 1'b1};
    end else begin
      rem_o = w_shift[31:0];
      quo_o = {quo_i[30:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/hilo_md_sched.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_md_sched
//  Description : HI/LO multiply/divide sequencer for the EXE stage. Runs a
//                MUL_LAT-deep multiplier and a 32-step restoring divider,
//                owns HI/LO and commits them when the instruction leaves EXE
//                without flush or write-disable.
//                Optional build macro MD_DIV_EARLY_EN: divides by zero or
//                with |dividend| < |divisor| finish after one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_md_sched
  import hilo_md_sched_pkg::*;
#(
  parameter int MUL_LAT  = 2,
  parameter int DIV_ITER = MD_DIV_ITER
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [7:0]  req_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        out_allowin,
  input  logic        wr_disable,
  input  logic        flush,
  output logic        req_ready,
  output logic [31:0] result,
  output logic        busy,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);

  md_state_t            state_q, state_d;
  logic [MD_CNT_W-1:0]  cnt_q, cnt_d;

  md_op_t               w_op;
  logic                 w_is_mul, w_is_div, w_single;
  logic                 w_accept_mul, w_accept_div, w_commit, w_mt_en;
  logic [31:0]          w_abs1, w_abs2;
  logic                 w_div_early;

  // Multiplier operands and pipelined product chain
  logic [31:0]          a_q, b_q;
  logic                 sgn_q;
  logic [63:0]          w_ea, w_eb, w_prod;
  logic [63:0]          prod_q [MUL_LAT];

  // Divider state
  logic [31:0]          rem_q, quo_q, dvs_q;
  logic                 negq_q, negr_q, early_q, is_mul_q;
  logic [31:0]          w_rem_nx, w_quo_nx, w_rem_fix, w_quo_fix;

  assign w_op     = md_op_t'(req_op);
  assign w_is_mul = w_op.mult | w_op.multu;
  assign w_is_div = w_op.div  | w_op.divu;
  assign w_single = req_valid && !w_is_mul && !w_is_div &&
                    (w_op.mfhi | w_op.mflo | w_op.mthi | w_op.mtlo);
  assign w_abs1   = md_abs(src1, w_op.div);
  assign w_abs2   = md_abs(src2, w_op.div);
  assign busy     = (state_q != ST_IDLE);

`ifdef MD_DIV_EARLY_EN
  assign w_div_early = (src2 == 32'd0) || (w_abs1 < w_abs2);
`else
  assign w_div_early = 1'b0;
`endif

  // MT* writes happen on the edge where EXE advances the instruction
  assign w_mt_en = (state_q == ST_IDLE) && w_single && out_allowin &&
                   !wr_disable && !flush;

  // MF* read data is presented combinationally while the request is held
  assign result = (state_q == ST_IDLE && w_single) ?
                  (w_op.mfhi ? hi_q : (w_op.mflo ? lo_q : 32'd0)) : 32'd0;

  // State and iteration counter register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, handshake and commit decode; flush overrides everything
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    w_accept_mul = 1'b0;
    w_accept_div = 1'b0;
    w_commit     = 1'b0;
    req_ready    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = w_single;
        if (req_valid && !flush) begin
          if (w_is_mul) begin
            w_accept_mul = 1'b1;
            state_d      = ST_MUL;
            cnt_d        = MD_CNT_W'(MUL_LAT - 1);
          end else if (w_is_div) begin
            w_accept_div = 1'b1;
            state_d      = ST_DIV;
            cnt_d        = w_div_early ? '0 : MD_CNT_W'(DIV_ITER - 1);
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE: begin
        req_ready = 1'b1;
        if (out_allowin) begin
          state_d  = ST_IDLE;
          w_commit = !wr_disable && !flush;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  // Two's-complement wrap of the sign-extended operands yields the correct
  // low 64 bits for both signed and unsigned products.
  assign w_ea   = {{32{sgn_q & a_q[31]}}, a_q};
  assign w_eb   = {{32{sgn_q & b_q[31]}}, b_q};
  assign w_prod = w_ea * w_eb;

  // Multiplier operand capture at acceptance; later operand changes ignored
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
    end else if (w_accept_mul) begin
      a_q   <= src1;
      b_q   <= src2;
      sgn_q <= w_op.mult;
    end
  end

  // Product pipeline; operands stay frozen until the next accept, so the
  // tail stage remains valid while DONE waits for EXE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MUL_LAT; i++) prod_q[i] <= '0;
    end else begin
      prod_q[0] <= w_prod;
      for (int i = 1; i < MUL_LAT; i++) prod_q[i] <= prod_q[i-1];
    end
  end

  md_div_step u_div_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (w_rem_nx),
    .quo_o (w_quo_nx)
  );

  // Divider load at acceptance, then one restoring step per DIV cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      early_q  <= 1'b0;
      is_mul_q <= 1'b0;
    end else if (w_accept_mul) begin
      is_mul_q <= 1'b1;
    end else if (w_accept_div) begin
      is_mul_q <= 1'b0;
      dvs_q    <= w_abs2;
      negq_q   <= w_op.div & (src1[31] ^ src2[31]);
      negr_q   <= w_op.div & src1[31];
      early_q  <= w_div_early;
      if (w_div_early) begin
        // Final unsigned result is known up front: remainder is |dividend|
        rem_q <= w_abs1;
        quo_q <= (src2 == 32'd0) ? DIV_BY_ZERO_QUO : 32'd0;
      end else begin
        rem_q <= 32'd0;
        quo_q <= w_abs1;
      end
    end else if (state_q == ST_DIV && !early_q) begin
      rem_q <= w_rem_nx;
      quo_q <= w_quo_nx;
    end
  end

  assign w_quo_fix = md_neg_if(quo_q, negq_q);
  assign w_rem_fix = md_neg_if(rem_q, negr_q);

  // HI/LO architectural registers: DONE commit or MT* write
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (w_commit) begin
      hi_q <= is_mul_q ? prod_q[MUL_LAT-1][63:32] : w_rem_fix;
      lo_q <= is_mul_q ? prod_q[MUL_LAT-1][31:0]  : w_quo_fix;
    end else if (w_mt_en) begin
      if (w_op.mthi) hi_q <= src1;
      if (w_op.mtlo) lo_q <= src1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hilo_md_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_md_sched
//  Description : Directed scoreboard bench for hilo_md_sched. The driver
//                queues hand-computed results; a negedge monitor pops one
//                entry per completed instruction and checks result, then
//                HI/LO one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_md_sched;

  localparam int MUL_LAT = 2;
  localparam logic [7:0] OP_MULT  = 8'h80, OP_MULTU = 8'h40,
                         OP_DIV   = 8'h20, OP_DIVU  = 8'h10,
                         OP_MFHI  = 8'h08, OP_MFLO  = 8'h04,
                         OP_MTHI  = 8'h02, OP_MTLO  = 8'h01;
  localparam int LAT_MUL = MUL_LAT + 1;
  localparam int LAT_DIV = 33;
`ifdef MD_DIV_EARLY_EN
  localparam int LAT_EARLY = 2;
`else
  localparam int LAT_EARLY = LAT_DIV;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic [7:0]  req_op = '0;
  logic [31:0] src1 = '0, src2 = '0;
  logic        out_allowin = 1'b0, wr_disable = 1'b0, flush = 1'b0;
  logic        req_ready, busy;
  logic [31:0] result, hi_q, lo_q;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
  } sb_t;

  sb_t         sb_q[$];
  sb_t         pend;
  logic        pend_vld = 1'b0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] cur_hi = '0, cur_lo = '0;

  hilo_md_sched #(.MUL_LAT(MUL_LAT)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .src1        (src1),
    .src2        (src2),
    .out_allowin (out_allowin),
    .wr_disable  (wr_disable),
    .flush       (flush),
    .req_ready   (req_ready),
    .result      (result),
    .busy        (busy),
    .hi_q        (hi_q),
    .lo_q        (lo_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: one pop per instruction leaving EXE; HI/LO checked next cycle
  always @(negedge clk) begin
    if (pend_vld) begin
      chk({pend.name, ".hi"}, hi_q, pend.hi);
      chk({pend.name, ".lo"}, lo_q, pend.lo);
      pend_vld = 1'b0;
    end
    if (resetn && req_ready && out_allowin) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_completion", 32'd1, 32'd0);
      end else begin
        pend = sb_q.pop_front();
        chk({pend.name, ".result"}, result, pend.res);
        pend_vld = 1'b1;
      end
    end
  end

  // Issue one instruction, measure cycles to req_ready, optionally stall EXE
  task automatic run_op(input string name, input logic [7:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic wd, input int hold, input int e_lat,
                        input logic [31:0] e_res, input logic [31:0] e_hi,
                        input logic [31:0] e_lo);
    sb_t it;
    int  n;
    it.name = name; it.res = e_res; it.hi = e_hi; it.lo = e_lo;
    sb_q.push_back(it);
    req_op = op; src1 = a; src2 = b; wr_disable = wd;
    out_allowin = (hold == 0); req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      src1 = 32'h5A5A_0000 ^ n;       // operands must be ignored after accept
      src2 = 32'h0000_A5A5 + n;
      n++;
      @(negedge clk);
    end
    chk({name, ".latency"}, n, e_lat);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({name, ".hold_ready"}, {31'd0, req_ready}, 32'd1);
      chk({name, ".hold_hi"}, hi_q, cur_hi);
    end
    out_allowin = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; out_allowin = 1'b0; wr_disable = 1'b0;
    cur_hi = e_hi; cur_lo = e_lo;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.ready", {31'd0, req_ready}, 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.hi", hi_q, 32'd0);
    chk("rst.lo", lo_q, 32'd0);
    @(posedge clk); #1;

    run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 0, LAT_MUL,
           32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("mfhi1", OP_MFHI, 32'd0, 32'd0, 1'b0, 0, 0,
           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("divu100_7", OP_DIVU, 32'd100, 32'd7, 1'b0, 0, LAT_DIV,
           32'd0, 32'd2, 32'd14);
    run_op("div-7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, LAT_DIV,
           32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu5_0", OP_DIVU, 32'd5, 32'd0, 1'b0, 0, LAT_EARLY,
           32'd0, 32'd5, 32'hFFFF_FFFF);

    // Flush mid-divide: back to IDLE at once, HI/LO untouched
    req_op = OP_DIV; src1 = 32'd1000; src2 = 32'd3; out_allowin = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("flush.busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_allowin = 1'b0;
    chk("flush.busy_after", {31'd0, busy}, 32'd0);
    chk("flush.hi", hi_q, 32'd5);
    chk("flush.lo", lo_q, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    run_op("mflo_after_flush", OP_MFLO, 32'd0, 32'd0, 1'b0, 0, 0,
           32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF);

    run_op("div3_-10", OP_DIV, 32'd3, 32'hFFFF_FFF6, 1'b0, 0, LAT_EARLY,
           32'd0, 32'd3, 32'd0);

    // Flush and request in the same IDLE cycle: nothing accepted
    req_op = OP_MULT; src1 = 32'd9; src2 = 32'd9; req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_req.busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    run_op("mthi_wd", OP_MTHI, 32'h1234_5678, 32'd0, 1'b1, 0, 0,
           32'd0, 32'd3, 32'd0);
    run_op("mthi", OP_MTHI, 32'h1234_5678, 32'd0, 1'b0, 0, 0,
           32'd0, 32'h1234_5678, 32'd0);
    run_op("mfhi2", OP_MFHI, 32'd0, 32'd0, 1'b0, 0, 0,
           32'h1234_5678, 32'h1234_5678, 32'd0);
    run_op("mtlo", OP_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0, 0, 0,
           32'd0, 32'h1234_5678, 32'hCAFE_F00D);
    run_op("mult_wd", OP_MULT, 32'd7, 32'd6, 1'b1, 0, LAT_MUL,
           32'd0, 32'h1234_5678, 32'hCAFE_F00D);
    run_op("multu_hold", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5, LAT_MUL,
           32'd0, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mflo_b2b", OP_MFLO, 32'd0, 32'd0, 1'b0, 0, 0,
           32'd1, 32'hFFFF_FFFE, 32'h0000_0001);

    // Asynchronous reset in the middle of a divide
    req_op = OP_DIVU; src1 = 32'd1000; src2 = 32'd3; out_allowin = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("rst_mid.busy", {31'd0, busy}, 32'd0);
    chk("rst_mid.hi", hi_q, 32'd0);
    chk("rst_mid.lo", lo_q, 32'd0);
    #2 resetn = 1'b1;
    out_allowin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid.idle", {31'd0, busy}, 32'd0);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
